// File: rtl/hazard_scoreboard.sv
// Hazard controller for the 5-stage MIPS pipeline: forwarding selects, load/branch/HI-LO
// stalls, a MULT/DIV latency scoreboard and a saturating stall-cycle counter.
module hazard_scoreboard #(
  parameter int unsigned REG_ADDR_WIDTH    = 5,
  parameter int unsigned MULT_LATENCY      = 4,
  parameter int unsigned DIV_LATENCY       = 32,
  parameter int unsigned STALL_COUNT_WIDTH = 16,
  localparam int unsigned CNT_W            = $clog2(DIV_LATENCY + 1)
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [REG_ADDR_WIDTH-1:0]    Rs_decode,
  input  logic [REG_ADDR_WIDTH-1:0]    Rt_decode,
  input  logic                         branch_decode,
  input  logic                         using_HI_LO_decode,
  input  logic                         muldiv_start_decode,
  input  logic                         muldiv_is_div_decode,
  input  logic [REG_ADDR_WIDTH-1:0]    Rs_execute,
  input  logic [REG_ADDR_WIDTH-1:0]    Rt_execute,
  input  logic [REG_ADDR_WIDTH-1:0]    write_register_execute,
  input  logic                         register_write_execute,
  input  logic                         memory_to_register_execute,
  input  logic [REG_ADDR_WIDTH-1:0]    write_register_memory,
  input  logic                         register_write_memory,
  input  logic                         memory_to_register_memory,
  input  logic [REG_ADDR_WIDTH-1:0]    write_register_writeback,
  input  logic                         register_write_writeback,
  input  logic                         program_counter_multiplexer_jump_execute,
  output logic                         stall_fetch,
  output logic                         stall_decode,
  output logic                         flush_execute_register,
  output logic                         forward_register_file_output_A_decode,
  output logic                         forward_register_file_output_B_decode,
  output logic [1:0]                   forward_register_file_output_A_execute,
  output logic [1:0]                   forward_register_file_output_B_execute,
  output logic                         hi_lo_busy,
  output logic [CNT_W-1:0]             muldiv_cycles_remaining,
  output logic [STALL_COUNT_WIDTH-1:0] stall_cycle_count
);

  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [STALL_COUNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic                         lwstall, branchstall, muldiv_stall, hazard, issue;

  // Register 0 is hardwired, so it never produces a dependency.
  function automatic logic dep(input logic [REG_ADDR_WIDTH-1:0] src,
                               input logic [REG_ADDR_WIDTH-1:0] dst,
                               input logic                      wr);
    return wr && (src != '0) && (src == dst);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_WIDTH-1:0] src);
    if (dep(src, write_register_memory, register_write_memory))
      return 2'b10;
    else if (dep(src, write_register_writeback, register_write_writeback))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  always_comb begin
    forward_register_file_output_A_execute = fwd_sel(Rs_execute);
    forward_register_file_output_B_execute = fwd_sel(Rt_execute);
    forward_register_file_output_A_decode  = dep(Rs_decode, write_register_memory, register_write_memory);
    forward_register_file_output_B_decode  = dep(Rt_decode, write_register_memory, register_write_memory);

    lwstall = dep(Rs_decode, write_register_execute, memory_to_register_execute) ||
              dep(Rt_decode, write_register_execute, memory_to_register_execute);

    branchstall = branch_decode &&
                  (dep(Rs_decode, write_register_execute, register_write_execute)   ||
                   dep(Rt_decode, write_register_execute, register_write_execute)   ||
                   dep(Rs_decode, write_register_memory, memory_to_register_memory) ||
                   dep(Rt_decode, write_register_memory, memory_to_register_memory));

    hi_lo_busy   = (cnt_q != '0);
    muldiv_stall = hi_lo_busy && (using_HI_LO_decode || muldiv_start_decode);

    hazard                 = lwstall || branchstall || muldiv_stall;
    // A resolving jump holds fetch/decode but leaves execute intact.
    stall_decode           = hazard || program_counter_multiplexer_jump_execute;
    stall_fetch            = stall_decode;
    flush_execute_register = hazard;

    issue = muldiv_start_decode && !stall_decode;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (issue)
      cnt_d = muldiv_is_div_decode ? CNT_W'(DIV_LATENCY) : CNT_W'(MULT_LATENCY);
    else if (cnt_q != '0)
      cnt_d = cnt_q - CNT_W'(1);

    stall_cnt_d = stall_cnt_q;
    if (stall_decode && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + STALL_COUNT_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign muldiv_cycles_remaining = cnt_q;
  assign stall_cycle_count       = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: default instance plus a 4-bit stall counter instance.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [4:0] Rs_decode, Rt_decode, Rs_execute, Rt_execute;
  logic [4:0] write_register_execute, write_register_memory, write_register_writeback;
  logic       branch_decode, using_HI_LO_decode, muldiv_start_decode, muldiv_is_div_decode;
  logic       register_write_execute, memory_to_register_execute;
  logic       register_write_memory, memory_to_register_memory, register_write_writeback;
  logic       jump_execute;

  logic       stall_fetch, stall_decode, flush_execute_register;
  logic       fwd_a_dec, fwd_b_dec;
  logic [1:0] fwd_a_ex, fwd_b_ex;
  logic       hi_lo_busy;
  logic [5:0] cycles_remaining;
  logic [15:0] stall_count;

  logic       w4_stall_fetch, w4_stall_decode, w4_flush;
  logic       w4_fwd_a_dec, w4_fwd_b_dec;
  logic [1:0] w4_fwd_a_ex, w4_fwd_b_ex;
  logic       w4_busy;
  logic [5:0] w4_cycles;
  logic [3:0] w4_stall_count;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk(clk), .reset_n(reset_n),
    .Rs_decode(Rs_decode), .Rt_decode(Rt_decode),
    .branch_decode(branch_decode), .using_HI_LO_decode(using_HI_LO_decode),
    .muldiv_start_decode(muldiv_start_decode), .muldiv_is_div_decode(muldiv_is_div_decode),
    .Rs_execute(Rs_execute), .Rt_execute(Rt_execute),
    .write_register_execute(write_register_execute),
    .register_write_execute(register_write_execute),
    .memory_to_register_execute(memory_to_register_execute),
    .write_register_memory(write_register_memory),
    .register_write_memory(register_write_memory),
    .memory_to_register_memory(memory_to_register_memory),
    .write_register_writeback(write_register_writeback),
    .register_write_writeback(register_write_writeback),
    .program_counter_multiplexer_jump_execute(jump_execute),
    .stall_fetch(stall_fetch), .stall_decode(stall_decode),
    .flush_execute_register(flush_execute_register),
    .forward_register_file_output_A_decode(fwd_a_dec),
    .forward_register_file_output_B_decode(fwd_b_dec),
    .forward_register_file_output_A_execute(fwd_a_ex),
    .forward_register_file_output_B_execute(fwd_b_ex),
    .hi_lo_busy(hi_lo_busy),
    .muldiv_cycles_remaining(cycles_remaining),
    .stall_cycle_count(stall_count)
  );

  hazard_scoreboard #(.STALL_COUNT_WIDTH(4)) dut_w4 (
    .clk(clk), .reset_n(reset_n),
    .Rs_decode(Rs_decode), .Rt_decode(Rt_decode),
    .branch_decode(branch_decode), .using_HI_LO_decode(using_HI_LO_decode),
    .muldiv_start_decode(muldiv_start_decode), .muldiv_is_div_decode(muldiv_is_div_decode),
    .Rs_execute(Rs_execute), .Rt_execute(Rt_execute),
    .write_register_execute(write_register_execute),
    .register_write_execute(register_write_execute),
    .memory_to_register_execute(memory_to_register_execute),
    .write_register_memory(write_register_memory),
    .register_write_memory(register_write_memory),
    .memory_to_register_memory(memory_to_register_memory),
    .write_register_writeback(write_register_writeback),
    .register_write_writeback(register_write_writeback),
    .program_counter_multiplexer_jump_execute(jump_execute),
    .stall_fetch(w4_stall_fetch), .stall_decode(w4_stall_decode),
    .flush_execute_register(w4_flush),
    .forward_register_file_output_A_decode(w4_fwd_a_dec),
    .forward_register_file_output_B_decode(w4_fwd_b_dec),
    .forward_register_file_output_A_execute(w4_fwd_a_ex),
    .forward_register_file_output_B_execute(w4_fwd_b_ex),
    .hi_lo_busy(w4_busy),
    .muldiv_cycles_remaining(w4_cycles),
    .stall_cycle_count(w4_stall_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    Rs_decode = '0; Rt_decode = '0; Rs_execute = '0; Rt_execute = '0;
    write_register_execute = '0; write_register_memory = '0; write_register_writeback = '0;
    branch_decode = 1'b0; using_HI_LO_decode = 1'b0;
    muldiv_start_decode = 1'b0; muldiv_is_div_decode = 1'b0;
    register_write_execute = 1'b0; memory_to_register_execute = 1'b0;
    register_write_memory = 1'b0; memory_to_register_memory = 1'b0;
    register_write_writeback = 1'b0; jump_execute = 1'b0;
  endtask

  // Advance one edge; inputs are then changed 1 time unit after it, checks 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_stall(input string tag, input logic s, input logic f);
    #1;
    check({tag, "_stall_fetch"},  {31'd0, stall_fetch},  {31'd0, s});
    check({tag, "_stall_decode"}, {31'd0, stall_decode}, {31'd0, s});
    check({tag, "_flush"},        {31'd0, flush_execute_register}, {31'd0, f});
  endtask

  initial begin
    clear_inputs();
    reset_n = 1'b0;
    #12;
    check("rst_cnt",   cycles_remaining, 0);
    check("rst_busy",  hi_lo_busy, 0);
    check("rst_perf",  stall_count, 0);
    check("rst_stall", stall_decode, 0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Execute and decode forwarding
    write_register_memory = 5; register_write_memory = 1;
    write_register_writeback = 5; register_write_writeback = 1;
    Rs_execute = 5; Rt_execute = 5; Rs_decode = 5; Rt_decode = 6;
    #1;
    check("fwd_a_ex_mem", fwd_a_ex, 2);
    check("fwd_b_ex_mem", fwd_b_ex, 2);
    check("fwd_a_dec",    fwd_a_dec, 1);
    check("fwd_b_dec",    fwd_b_dec, 0);
    register_write_memory = 0;
    #1;
    check("fwd_a_ex_wb",  fwd_a_ex, 1);
    check("fwd_a_dec_off", fwd_a_dec, 0);
    Rs_execute = 0; write_register_memory = 0; write_register_writeback = 0;
    register_write_memory = 1;
    #1;
    check("fwd_a_ex_r0",  fwd_a_ex, 0);
    check("fwd_b_ex_r5",  fwd_b_ex, 0);
    check_stall("fwd", 0, 0);

    // Load-use stall, one cycle
    clear_inputs();
    memory_to_register_execute = 1; register_write_execute = 1;
    write_register_execute = 8; Rt_decode = 8;
    check_stall("lw", 1, 1);
    tick();
    check("lw_perf", stall_count, 1);
    clear_inputs();
    check_stall("lw_after", 0, 0);
    memory_to_register_execute = 1;
    check_stall("lw_r0", 0, 0);
    tick();
    check("lw_perf_hold", stall_count, 1);

    // Branch against ALU result in execute, then forwarded from memory
    clear_inputs();
    branch_decode = 1; Rs_decode = 3;
    register_write_execute = 1; write_register_execute = 3;
    check_stall("br_ex", 1, 1);
    tick();
    register_write_execute = 0; write_register_execute = 0;
    write_register_memory = 3; register_write_memory = 1;
    check_stall("br_mem", 0, 0);
    check("br_fwd_a_dec", fwd_a_dec, 1);
    memory_to_register_memory = 1;
    check_stall("br_load_mem", 1, 1);
    clear_inputs();
    jump_execute = 1;
    check_stall("jump", 1, 0);
    clear_inputs();
    tick();
    check("br_perf", stall_count, 2);

    // DIV then MFLO held in decode
    muldiv_start_decode = 1; muldiv_is_div_decode = 1;
    check_stall("div_issue", 0, 0);
    tick();
    clear_inputs();
    using_HI_LO_decode = 1;
    for (int i = 32; i >= 1; i--) begin
      #1;
      if (cycles_remaining !== 6'(i) || !stall_decode || !flush_execute_register || !hi_lo_busy)
        check($sformatf("div_cnt_%0d", i), {cycles_remaining, stall_decode, flush_execute_register, hi_lo_busy},
              {6'(i), 3'b111});
      else
        n_checks++;
      tick();
    end
    check("div_cnt_done", cycles_remaining, 0);
    check_stall("mflo_go", 0, 0);
    check("div_perf", stall_count, 34);
    clear_inputs();
    tick();

    // MULT blocked by load-use, then issued, then a second MULT waits
    muldiv_start_decode = 1;
    memory_to_register_execute = 1; write_register_execute = 8; Rt_decode = 8;
    check_stall("mult_lw", 1, 1);
    tick();
    check("mult_no_load", cycles_remaining, 0);
    memory_to_register_execute = 0; write_register_execute = 0; Rt_decode = 0;
    check_stall("mult_go", 0, 0);
    tick();
    check("mult_load", cycles_remaining, 4);
    muldiv_start_decode = 0;
    tick(); tick();
    check("mult_cnt2", cycles_remaining, 2);
    muldiv_start_decode = 1;
    check_stall("mult2_wait2", 1, 1);
    tick();
    check_stall("mult2_wait1", 1, 1);
    tick();
    check("mult2_cnt0", cycles_remaining, 0);
    check_stall("mult2_go", 0, 0);
    tick();
    check("mult2_reload", cycles_remaining, 4);
    check("mult_perf", stall_count, 37);

    // Asynchronous reset mid-DIV
    clear_inputs();
    repeat (4) tick();
    muldiv_start_decode = 1; muldiv_is_div_decode = 1;
    tick();
    clear_inputs();
    repeat (22) tick();
    check("pre_rst_cnt", cycles_remaining, 10);
    reset_n = 1'b0;
    #1;
    check("rst_mid_cnt",  cycles_remaining, 0);
    check("rst_mid_busy", hi_lo_busy, 0);
    check("rst_mid_perf", stall_count, 0);
    @(negedge clk);
    reset_n = 1'b1;
    using_HI_LO_decode = 1;
    check_stall("post_rst", 0, 0);
    tick();

    // Saturation of the 4-bit stall counter
    clear_inputs();
    jump_execute = 1;
    repeat (14) tick();
    check("w4_perf_14", w4_stall_count, 14);
    repeat (6) tick();
    check("w4_perf_sat", w4_stall_count, 15);
    check("perf_20", stall_count, 20);
    clear_inputs();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Pipeline hazard controller for the 5-stage MIPS core. Generalises register-address width.
- Adds a sequential HI/LO scoreboard for multi-cycle MULT/DIV, with separately parametrised latencies.
- Adds a saturating stall-cycle performance counter.
- Sits beside the pipeline registers. Drives fetch/decode stalls, the execute-register flush and all forwarding muxes.

Parameters:
- REG_ADDR_WIDTH, 5, register index width.
- MULT_LATENCY, 4, cycles from MULT issue until HI/LO are valid.
- DIV_LATENCY, 32, cycles from DIV issue until HI/LO are valid; must be >= MULT_LATENCY.
- STALL_COUNT_WIDTH, 16, width of the stall performance counter.

Ports:
- clk, input, 1, clock, rising edge.
- reset_n, input, 1, reset; asynchronous, active-low.
- Rs_decode / Rt_decode, input, REG_ADDR_WIDTH, source registers in decode.
- branch_decode, input, 1, decode holds a branch.
- using_HI_LO_decode, input, 1, decode holds MFHI/MFLO.
- muldiv_start_decode, input, 1, decode holds MULT/MULTU/DIV/DIVU.
- muldiv_is_div_decode, input, 1, 1 = divide, 0 = multiply.
- Rs_execute / Rt_execute, input, REG_ADDR_WIDTH, execute sources.
- write_register_execute, input, REG_ADDR_WIDTH, execute destination.
- register_write_execute / memory_to_register_execute, input, 1, execute controls.
- write_register_memory, input, REG_ADDR_WIDTH, memory-stage destination.
- register_write_memory / memory_to_register_memory, input, 1, memory-stage controls.
- write_register_writeback, input, REG_ADDR_WIDTH, writeback destination.
- register_write_writeback, input, 1, writeback control.
- program_counter_multiplexer_jump_execute, input, 1, jump resolving in execute.
- stall_fetch / stall_decode, output, 1, hold the PC / hold the decode register.
- flush_execute_register, output, 1, insert a bubble into execute.
- forward_register_file_output_A_decode / ..._B_decode, output, 1, forward the memory-stage ALU result to the branch comparator.
- forward_register_file_output_A_execute / ..._B_execute, output, 2, select: 00 = register file, 01 = writeback, 10 = memory.
- hi_lo_busy, output, 1, a MULT/DIV is in flight.
- muldiv_cycles_remaining, output, clog2(DIV_LATENCY+1), scoreboard counter.
- stall_cycle_count, output, STALL_COUNT_WIDTH, saturating count of stalled cycles.

Behaviour:
- Reset: async on reset_n low. muldiv_cycles_remaining = 0, stall_cycle_count = 0, hi_lo_busy = 0. All other outputs are combinational and follow the inputs.
- Execute forwarding, per operand:
  - 10 if reg != 0, reg == write_register_memory and register_write_memory;
  - else 01 if the same condition holds for writeback;
  - else 00. Memory has priority over writeback.
- Decode forwarding: A = Rs_decode != 0 && Rs_decode == write_register_memory && register_write_memory. B is the same with Rt_decode.
- lwstall = memory_to_register_execute && write_register_execute != 0 && (Rs_decode or Rt_decode == write_register_execute).
- branchstall = branch_decode && either:
  - register_write_execute and write_register_execute != 0 matching Rs_decode/Rt_decode; or
  - memory_to_register_memory and write_register_memory != 0 matching Rs_decode/Rt_decode.
- muldiv_stall = hi_lo_busy && (using_HI_LO_decode || muldiv_start_decode).
- stall_fetch = stall_decode = lwstall || branchstall || muldiv_stall || program_counter_multiplexer_jump_execute.
- flush_execute_register = lwstall || branchstall || muldiv_stall. A jump alone stalls but does not flush.
- Scoreboard:
  - hi_lo_busy = (muldiv_cycles_remaining != 0).
  - issue = muldiv_start_decode && !stall_decode.
  - On each clk edge: if issue, load DIV_LATENCY when muldiv_is_div_decode, otherwise MULT_LATENCY. Else, if the counter is nonzero, decrement it. Else hold.
  - Issue and decrement never coincide, because issue requires !hi_lo_busy.
  - A counter value of 1 means decode is released on the next cycle. MFHI at count 0 proceeds with no stall.
- Perf counter: increments on each edge where stall_decode = 1. It saturates at all-ones and never wraps.
- Reset mid-operation: the counter clears asynchronously and hi_lo_busy drops the same cycle. No residual stall remains after reset_n rises.
- Register 0 is never a hazard source for forwarding, lwstall or branchstall.

Test Plan:
- Memory and writeback both write $5, Rs_execute = 5 → A_execute = 10. Remove the memory write → 01. Set Rs_execute = 0 with matching writes → 00.
- LW to $8 in execute, Rt_decode = 8 → stall_fetch = stall_decode = flush = 1 for one cycle; stall_cycle_count increments by 1.
- BEQ in decode, Rs_decode = 3; an ALU op writing $3 in execute → branchstall. The next cycle, with $3 in the memory stage and register_write_memory = 1 → no stall and forward_A_decode = 1.
- Issue a DIV with no stall, then hold MFLO in decode → counter reads 32,31,…,1. Stall and flush stay high for exactly 32 cycles, then MFLO proceeds at count 0.
- Issue a MULT while lwstall is active → no load. The same MULT issued the next cycle → counter = 4. A second MULT arrives while the counter = 2 → it stalls until count 0, then reloads 4.
- Assert reset_n low with the counter = 10 → counter = 0 and hi_lo_busy = 0 immediately. With STALL_COUNT_WIDTH = 4, 20 stalled cycles → stall_cycle_count = 15.
